// File: rtl/decode_scoreboard_if.sv
// Decode/WB-side handshake bundle for decode_scoreboard.
// master: decode + WB stages; slave: the scoreboard.
interface decode_scoreboard_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_regwrite;
  logic [4:0]  id_dest;
  logic        wb_regwrite;
  logic [4:0]  wb_dest;
  logic        flush;
  logic        id_stall;
  logic        id_issue;
  logic [31:0] pending_mask;
  logic [1:0]  inflight;
  logic        sb_error;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_regwrite, id_dest,
    output wb_regwrite, wb_dest, flush,
    input  id_stall, id_issue, pending_mask, inflight, sb_error
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_regwrite, id_dest,
    input  wb_regwrite, wb_dest, flush,
    output id_stall, id_issue, pending_mask, inflight, sb_error
  );
endinterface

// File: rtl/decode_scoreboard.sv
// Register-hazard scoreboard: per-register pending counters, decode stall and issue control.
// Optional macro SB_WB_BYPASS_EN: a source retiring in WB this cycle is not treated as pending.
module decode_scoreboard #(
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic           clk,
  input  logic           reset,
  decode_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [1:0]       INF_MAX = 2'(MAX_INFLIGHT);

  logic [CNT_W-1:0] r_cnt [1:31];
  logic [1:0]       r_inflight;
  logic             r_err;

  logic [CNT_W-1:0] w_cnt [32];
  logic [CNT_W-1:0] w_cnt_rs, w_cnt_rt, w_cnt_dest, w_cnt_wb;
  logic             w_byp_rs, w_byp_rt;
  logic             w_haz_rs, w_haz_rt, w_full, w_stall, w_issue;
  logic             w_inc, w_wb, w_wb_err, w_dec;
  logic [31:0]      w_inc_vec, w_dec_vec, w_mask;

  // r0 is hard-wired to an empty counter so it never stalls or tracks
  always_comb begin
    w_cnt[0] = '0;
    for (int i = 1; i < 32; i++) w_cnt[i] = r_cnt[i];
  end

  assign w_cnt_rs   = w_cnt[sb.id_rs];
  assign w_cnt_rt   = w_cnt[sb.id_rt];
  assign w_cnt_dest = w_cnt[sb.id_dest];
  assign w_cnt_wb   = w_cnt[sb.wb_dest];

`ifdef SB_WB_BYPASS_EN
  // Last outstanding write retiring now: the register file forwards it to the read port
  assign w_byp_rs = sb.wb_regwrite & (sb.wb_dest == sb.id_rs) & (w_cnt_rs == CNT_ONE);
  assign w_byp_rt = sb.wb_regwrite & (sb.wb_dest == sb.id_rt) & (w_cnt_rt == CNT_ONE);
`else
  assign w_byp_rs = 1'b0;
  assign w_byp_rt = 1'b0;
`endif

  assign w_haz_rs = sb.id_uses_rs & (sb.id_rs != 5'd0) & (w_cnt_rs != '0) & ~w_byp_rs;
  assign w_haz_rt = sb.id_uses_rt & (sb.id_rt != 5'd0) & (w_cnt_rt != '0) & ~w_byp_rt;
  assign w_full   = sb.id_regwrite & (sb.id_dest != 5'd0) &
                    ((r_inflight == INF_MAX) | (w_cnt_dest == CNT_MAX));
  assign w_stall  = sb.id_valid & (w_haz_rs | w_haz_rt | w_full);
  assign w_issue  = sb.id_valid & ~w_stall;

  assign w_inc    = w_issue & sb.id_regwrite & (sb.id_dest != 5'd0);
  assign w_wb     = sb.wb_regwrite & (sb.wb_dest != 5'd0);
  // Retiring a write that was never issued is a protocol error and is dropped
  assign w_wb_err = w_wb & ((w_cnt_wb == '0) | (r_inflight == 2'd0));
  assign w_dec    = w_wb & ~w_wb_err;

  assign w_inc_vec = w_inc ? (32'd1 << sb.id_dest) : 32'd0;
  assign w_dec_vec = w_dec ? (32'd1 << sb.wb_dest) : 32'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) r_cnt[i] <= '0;
    end else if (sb.flush) begin
      for (int i = 1; i < 32; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_inc_vec[i] && !w_dec_vec[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end else if (w_dec_vec[i] && !w_inc_vec[i]) begin
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight <= 2'd0;
    end else if (sb.flush) begin
      r_inflight <= 2'd0;
    end else if (w_inc && !w_dec) begin
      r_inflight <= r_inflight + 2'd1;
    end else if (w_dec && !w_inc) begin
      r_inflight <= r_inflight - 2'd1;
    end
  end

  // Sticky until reset; flush deliberately leaves it alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_wb_err) begin
      r_err <= 1'b1;
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 1; i < 32; i++) w_mask[i] = (w_cnt[i] != '0);
  end

  assign sb.id_stall     = w_stall;
  assign sb.id_issue     = w_issue;
  assign sb.pending_mask = w_mask;
  assign sb.inflight     = r_inflight;
  assign sb.sb_error     = r_err;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Table-driven self-checking bench for decode_scoreboard; expectations flow through a queue.
module tb_decode_scoreboard;

  typedef struct {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        urs;
    logic        urt;
    logic        rw;
    logic [4:0]  dest;
    logic        wbw;
    logic [4:0]  wbd;
    logic        flush;
    logic        e_stall;
    logic        e_issue;
    logic [31:0] e_mask;
    logic [1:0]  e_inf;
    logic        e_err;
  } vec_t;

`ifdef SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs [$];
  vec_t exp_q [$];

  decode_scoreboard_if u_if ();

  decode_scoreboard u_dut (
    .clk   (clk),
    .reset (reset),
    .sb    (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic valid, input logic [4:0] rs, input logic [4:0] rt, input logic urs,
    input logic urt, input logic rw, input logic [4:0] dest, input logic wbw,
    input logic [4:0] wbd, input logic flush, input logic e_stall, input logic e_issue,
    input logic [31:0] e_mask, input logic [1:0] e_inf, input logic e_err);
    vec_t v;
    v.valid = valid; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.rw = rw;
    v.dest = dest; v.wbw = wbw; v.wbd = wbd; v.flush = flush;
    v.e_stall = e_stall; v.e_issue = e_issue; v.e_mask = e_mask; v.e_inf = e_inf;
    v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    u_if.id_valid    = v.valid;
    u_if.id_rs       = v.rs;
    u_if.id_rt       = v.rt;
    u_if.id_uses_rs  = v.urs;
    u_if.id_uses_rt  = v.urt;
    u_if.id_regwrite = v.rw;
    u_if.id_dest     = v.dest;
    u_if.wb_regwrite = v.wbw;
    u_if.wb_dest     = v.wbd;
    u_if.flush       = v.flush;
  endtask

  task automatic check_outputs(input int row);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty row %0d got 0 expected 1", row);
    end else begin
      e = exp_q.pop_front();
      chk("id_stall", row, 32'(u_if.id_stall), 32'(e.e_stall));
      chk("id_issue", row, 32'(u_if.id_issue), 32'(e.e_issue));
      chk("pending_mask", row, u_if.pending_mask, e.e_mask);
      chk("inflight", row, 32'(u_if.inflight), 32'(e.e_inf));
      chk("sb_error", row, 32'(u_if.sb_error), 32'(e.e_err));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));

    //      vld rs rt urs urt rw dst wbw wbd fl | stall issue mask inf err
    vecs.push_back(mk(0, 0,0,0,0, 0, 0, 0, 0,0, 0,0,32'h0,   0,0)); // idle after reset
    vecs.push_back(mk(1, 0,0,0,0, 1, 8, 0, 0,0, 0,1,32'h0,   0,0)); // issue write r8
    vecs.push_back(mk(1, 8,0,1,0, 0, 0, 0, 0,0, 1,0,32'h100, 1,0)); // read r8 stalls
    vecs.push_back(mk(1, 8,0,1,0, 0, 0, 1, 8,0, !BYP,BYP,32'h100,1,0)); // WB r8
    vecs.push_back(mk(1, 8,0,1,0, 0, 0, 0, 0,0, 0,1,32'h0,   0,0)); // released
    vecs.push_back(mk(1, 0,0,0,0, 1, 0, 0, 0,0, 0,1,32'h0,   0,0)); // write r0
    vecs.push_back(mk(1, 0,0,1,0, 0, 0, 0, 0,0, 0,1,32'h0,   0,0)); // read r0
    vecs.push_back(mk(1, 0,0,0,0, 1, 1, 0, 0,0, 0,1,32'h0,   0,0)); // write r1
    vecs.push_back(mk(1, 0,0,0,0, 1, 2, 0, 0,0, 0,1,32'h2,   1,0)); // write r2
    vecs.push_back(mk(1, 0,0,0,0, 1, 3, 0, 0,0, 0,1,32'h6,   2,0)); // write r3
    vecs.push_back(mk(1, 0,0,0,0, 1, 4, 0, 0,0, 1,0,32'hE,   3,0)); // r4 blocked: full
    vecs.push_back(mk(1, 0,0,0,0, 1, 4, 1, 2,0, 1,0,32'hE,   3,0)); // WB r2, still full
    vecs.push_back(mk(1, 0,0,0,0, 1, 4, 0, 0,0, 0,1,32'hA,   2,0)); // r4 issues
    vecs.push_back(mk(0, 0,0,0,0, 0, 0, 0, 0,0, 0,0,32'h1A,  3,0));
    vecs.push_back(mk(0, 0,0,0,0, 0, 0, 1, 1,0, 0,0,32'h1A,  3,0)); // WB r1
    vecs.push_back(mk(0, 0,0,0,0, 0, 0, 1, 3,0, 0,0,32'h18,  2,0)); // WB r3
    vecs.push_back(mk(0, 0,0,0,0, 0, 0, 1, 4,0, 0,0,32'h10,  1,0)); // WB r4
    vecs.push_back(mk(1, 0,0,0,0, 1, 9, 0, 0,0, 0,1,32'h0,   0,0)); // write r9
    vecs.push_back(mk(1, 0,0,0,0, 1, 9, 1, 9,0, 0,1,32'h200, 1,0)); // issue+WB r9
    vecs.push_back(mk(0, 0,0,0,0, 0, 0, 0, 0,0, 0,0,32'h200, 1,0)); // cnt9 still 1
    vecs.push_back(mk(1, 0,0,0,0, 1,10, 0, 0,0, 0,1,32'h200, 1,0)); // write r10
    vecs.push_back(mk(1, 9,0,1,0, 0, 0, 0, 0,1, 1,0,32'h600, 2,0)); // flush, pre-flush stall
    vecs.push_back(mk(0, 0,0,0,0, 0, 0, 0, 0,0, 0,0,32'h0,   0,0)); // cleared
    vecs.push_back(mk(0, 0,0,0,0, 0, 0, 1,12,0, 0,0,32'h0,   0,0)); // bogus WB r12
    vecs.push_back(mk(0, 0,0,0,0, 0, 0, 0, 0,0, 0,0,32'h0,   0,1)); // error set
    vecs.push_back(mk(0, 0,0,0,0, 0, 0, 0, 0,1, 0,0,32'h0,   0,1)); // flush keeps error
    vecs.push_back(mk(1, 0,0,0,0, 1, 5, 0, 0,0, 0,1,32'h0,   0,1)); // write r5
    vecs.push_back(mk(1, 0,5,0,1, 0, 0, 0, 0,0, 1,0,32'h20,  1,1)); // rt hazard
    vecs.push_back(mk(1, 5,5,0,0, 0, 0, 0, 0,0, 0,1,32'h20,  1,1)); // unused sources

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      check_outputs(i);
    end

    // Asynchronous reset mid-cycle with cnt[5]=1 and a dependent read presented
    @(posedge clk);
    #1;
    drive(mk(1,5,0,1,0,0,0,0,0,0, 0,0,0,0,0));
    #1;
    chk("pre_reset_stall", 100, 32'(u_if.id_stall), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_pending_mask", 101, u_if.pending_mask, 32'h0);
    chk("rst_inflight", 101, 32'(u_if.inflight), 32'd0);
    chk("rst_sb_error", 101, 32'(u_if.sb_error), 32'd0);
    chk("rst_id_stall", 101, 32'(u_if.id_stall), 32'd0);
    chk("rst_id_issue", 101, 32'(u_if.id_issue), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    @(negedge clk);
    chk("post_rst_mask", 102, u_if.pending_mask, 32'h0);
    chk("post_rst_stall", 102, 32'(u_if.id_stall), 32'd0);
    chk("post_rst_issue", 102, 32'(u_if.id_issue), 32'd0);
    chk("post_rst_err", 102, 32'(u_if.sb_error), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_scoreboard.md
# decode_scoreboard

Register-hazard scoreboard and issue controller for the decode stage. Tracks every in-flight register write between decode issue and writeback, holds the decode stage while a source operand is still pending, and releases it when the writeback stage retires the producing instruction. Sits beside the decode stage: it reads source and destination fields from the instruction word and receives write-back notifications from the WB stage.

## Interface
- `CNT_W`, 2: width of each per-register pending counter; saturation value is `2**CNT_W-1`.
- `MAX_INFLIGHT`, 3: maximum number of register-writing instructions between issue and writeback.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `id_valid` in 1: the decode stage holds a valid instruction.
- `id_rs` in 5: source register 1 (`instr[25:21]`).
- `id_rt` in 5: source register 2 (`instr[20:16]`).
- `id_uses_rs` in 1: the instruction reads `id_rs`.
- `id_uses_rt` in 1: the instruction reads `id_rt`.
- `id_regwrite` in 1: the instruction writes a register.
- `id_dest` in 5: destination register, already resolved between `[20:16]` and `[15:11]`.
- `wb_regwrite` in 1: the WB stage writes a register this cycle.
- `wb_dest` in 5: register written by the WB stage.
- `flush` in 1: synchronous pipeline flush; clears all pending state.
- `id_stall` out 1: hold the decode stage and insert a bubble (combinational).
- `id_issue` out 1: the instruction leaves decode this cycle; equals `id_valid & ~id_stall`.
- `pending_mask` out 32: bit n is 1 when register n's counter is nonzero (registered).
- `inflight` out 2: number of register-writing instructions in flight (registered).
- `sb_error` out 1: sticky protocol-error flag.

## Operation
- State:
  - 31 counters, `cnt[1..31]`, each `CNT_W` bits wide. Register 0 is never tracked, so `pending_mask[0]` is always 0.
  - Global `inflight` counter.
  - `sb_error` bit.
- Hazard condition:
  - `haz_rs = id_uses_rs & (id_rs != 0) & (cnt[id_rs] != 0)`.
  - `haz_rt` is defined the same way for `id_rt`.
- Structural condition: `full = id_regwrite & (id_dest != 0) & ((inflight == MAX_INFLIGHT) | (cnt[id_dest] == max))`.
- Stall: `id_stall = id_valid & (haz_rs | haz_rt | full)`. When `id_valid` is 0, `id_stall` is 0.
- On issue with `id_regwrite & id_dest != 0`:
  - `cnt[id_dest]` increments.
  - `inflight` increments.
- On `wb_regwrite & wb_dest != 0`:
  - `cnt[wb_dest]` decrements.
  - `inflight` decrements.
- Simultaneous events:
  - Issue and WB to the same register: the counter is unchanged.
  - Issue and WB to different registers: both updates apply and `inflight` is unchanged.
- WB to a register whose counter is 0, or WB while `inflight` is 0:
  - Counter and `inflight` are left unchanged; no wrap.
  - `sb_error` is set to 1 and stays set until reset.
- `flush` clears all counters and `inflight` to 0 on the next edge and takes priority over same-cycle issue and WB.
  - `id_stall` for the flush cycle is still computed from the pre-flush state.
  - `sb_error` is not cleared by `flush`.
- Counters never exceed saturation, because `full` blocks the issue that would overflow them.

## Timing
- Reset values: all counters 0, `pending_mask` 0, `inflight` 0, `sb_error` 0. Under `id_valid=0`, `id_stall` and `id_issue` are 0.
- Reset mid-operation clears all state immediately, independent of `clk`.
- Update latency: an issue at edge k sets `pending_mask` and raises `id_stall` for a dependent instruction starting in cycle k+1.
- Release latency for a WB in cycle k:
  - The counter clears at edge k+1.
  - With the bypass macro defined, the dependent instruction issues in cycle k itself.
  - Without it, the dependent instruction issues in cycle k+1.
- `id_stall` is purely combinational from current inputs and registered state; there are no combinational paths from `id_stall` back into the inputs.

## Configuration
- `SB_WB_BYPASS_EN`, defined: in the hazard terms, a source register does not count as pending when `wb_regwrite & wb_dest == src & cnt[src] == 1`.
  - Requires that the register file forwards `Write_Data` to the read ports in the same cycle.
  - Saves one stall cycle per resolved dependency.
- Not defined: the hazard terms use the counters only, and a dependent instruction waits until the cycle after WB.

## Test plan
- Reset and idle:
  - Drive `reset=0` mid-run with `cnt[5]=1`, then release.
  - Required: `pending_mask=0`, `inflight=0`, `sb_error=0`, `id_stall=0`.
- Dependency stall and release:
  - Issue a write to r8, then present a read of `rs=8` with `id_valid=1`.
  - Required: `id_stall=1` until WB of r8.
  - Without the macro, `id_issue=1` in the cycle after WB.
  - With `SB_WB_BYPASS_EN`, `id_issue=1` in the WB cycle.
- r0 exemption:
  - Issue a write to r0, then read `rs=0`.
  - Required: `pending_mask=0`, `inflight=0`, and no stall.
- Structural full:
  - Issue 3 writes to r1, r2, r3 with no WB, then present a write to r4 with no sources.
  - Required: `inflight=3`, `id_stall=1`.
  - WB of r2 drops `inflight` to 2, and the r4 write then issues.
- Simultaneous issue and WB to the same register:
  - Set `cnt[9]=1`, then in one cycle issue a write to r9 and WB r9.
  - Required: `cnt[9]` stays 1, `inflight` unchanged, `pending_mask[9]=1`.
- Flush and error:
  - With `inflight=2`, assert `flush`.
  - Required: everything 0 next cycle.
  - Then WB r12 with `cnt[12]=0`.
  - Required: `sb_error=1`, `inflight` stays 0, and `sb_error` stays 1 until reset.
